// File: rtl/battle_front_ctrl_if.sv
// rtl/battle_front_ctrl_if.sv - combat-side bundle between the unit/enemy arrays and battle_front_ctrl
// The step input exists only when BATTLE_STEP_EN is defined.
interface battle_front_ctrl_if #(
  parameter int NUM_UNITS = 4,
  parameter int POS_W     = 9,
  parameter int DMG_W     = 8
);
  logic                       enable;
`ifdef BATTLE_STEP_EN
  logic                       step;
`endif
  logic [NUM_UNITS*POS_W-1:0] unit_pos;
  logic [NUM_UNITS*2-1:0]     unit_type;
  logic [NUM_UNITS*DMG_W-1:0] unit_dmg;
  logic [NUM_UNITS*POS_W-1:0] enemy_pos;
  logic [NUM_UNITS*2-1:0]     enemy_type;
  logic [NUM_UNITS*DMG_W-1:0] enemy_dmg;
  logic                       moveSCEN;
  logic                       damageSCEN;
  logic [POS_W-1:0]           enemy_front;
  logic [POS_W-1:0]           unit_front;
  logic [DMG_W-1:0]           damage_to_units;
  logic [DMG_W-1:0]           damage_to_enemies;
  logic                       overrun;

  modport master (
`ifdef BATTLE_STEP_EN
    output step,
`endif
    output enable, unit_pos, unit_type, unit_dmg, enemy_pos, enemy_type, enemy_dmg,
    input  moveSCEN, damageSCEN, enemy_front, unit_front,
    input  damage_to_units, damage_to_enemies, overrun
  );

  modport slave (
`ifdef BATTLE_STEP_EN
    input  step,
`endif
    input  enable, unit_pos, unit_type, unit_dmg, enemy_pos, enemy_type, enemy_dmg,
    output moveSCEN, damageSCEN, enemy_front, unit_front,
    output damage_to_units, damage_to_enemies, overrun
  );
endinterface

// File: rtl/battle_front_ctrl.sv
// rtl/battle_front_ctrl.sv - game-tick sequencer: front tracking and damage aggregation for both armies
// Optional BATTLE_STEP_EN: ticks come from a synchronized rising edge of bus.step instead of the divider.
module battle_front_ctrl #(
  parameter int NUM_UNITS = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int POS_W     = 9,
  parameter int DMG_W     = 8
) (
  input logic                clk,
  input logic                reset,
  battle_front_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int SUM_W = DMG_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_MOVE, S_SETTLE, S_DSCAN, S_DAMAGE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [POS_W-1:0] r_emax;
  logic [POS_W-1:0] r_umin;
  logic [POS_W-1:0] r_enemy_front;
  logic [POS_W-1:0] r_unit_front;
  logic [SUM_W-1:0] r_esum;
  logic [SUM_W-1:0] r_usum;
  logic             r_overrun;
  logic             w_tick;
  logic             w_last;

`ifdef BATTLE_STEP_EN
  // [0],[1] synchronize; [2] is the previous synchronized value for edge detection
  logic [2:0] r_step_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_step_sync <= '0;
    else        r_step_sync <= {r_step_sync[1:0], bus.step};
  end

  assign w_tick = bus.enable && r_step_sync[1] && !r_step_sync[2];
`else
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CNT_W-1:0] r_tick_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    r_tick_cnt <= '0;
    else if (!bus.enable)                          r_tick_cnt <= '0;
    else if (r_tick_cnt == CNT_W'(TICK_DIV - 1))   r_tick_cnt <= '0;
    else                                           r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  assign w_tick = bus.enable && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
`endif

  logic [POS_W-1:0] w_epos;
  logic [POS_W-1:0] w_upos;
  logic [DMG_W-1:0] w_edmg;
  logic [DMG_W-1:0] w_udmg;
  logic             w_ealive;
  logic             w_ualive;
  logic [POS_W-1:0] w_emax_nxt;
  logic [POS_W-1:0] w_umin_nxt;
  logic [SUM_W-1:0] w_esum_nxt;
  logic [SUM_W-1:0] w_usum_nxt;

  assign w_last   = (r_idx == IDX_W'(NUM_UNITS - 1));
  assign w_epos   = bus.enemy_pos[r_idx*POS_W +: POS_W];
  assign w_upos   = bus.unit_pos[r_idx*POS_W +: POS_W];
  assign w_edmg   = bus.enemy_dmg[r_idx*DMG_W +: DMG_W];
  assign w_udmg   = bus.unit_dmg[r_idx*DMG_W +: DMG_W];
  assign w_ealive = (bus.enemy_type[r_idx*2 +: 2] != 2'b00);
  assign w_ualive = (bus.unit_type[r_idx*2 +: 2] != 2'b00);

  assign w_emax_nxt = (w_ealive && (w_epos > r_emax)) ? w_epos : r_emax;
  assign w_umin_nxt = (w_ualive && (w_upos < r_umin)) ? w_upos : r_umin;
  assign w_esum_nxt = r_esum + (w_ealive ? {{IDX_W{1'b0}}, w_edmg} : '0);
  assign w_usum_nxt = r_usum + (w_ualive ? {{IDX_W{1'b0}}, w_udmg} : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_next_state = S_SCAN;
      S_SCAN:   if (w_last) w_next_state = S_MOVE;
      S_MOVE:   w_next_state = S_SETTLE;
      S_SETTLE: w_next_state = S_DSCAN;
      S_DSCAN:  if (w_last) w_next_state = S_DAMAGE;
      S_DAMAGE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.moveSCEN          = 1'b0;
    bus.damageSCEN        = 1'b0;
    bus.damage_to_units   = '0;
    bus.damage_to_enemies = '0;
    case (r_state)
      S_MOVE: bus.moveSCEN = 1'b1;
      S_DAMAGE: begin
        bus.damageSCEN        = 1'b1;
        bus.damage_to_units   = (|r_esum[SUM_W-1:DMG_W]) ? '1 : r_esum[DMG_W-1:0];
        bus.damage_to_enemies = (|r_usum[SUM_W-1:DMG_W]) ? '1 : r_usum[DMG_W-1:0];
      end
      default: ;
    endcase
  end

  // Fronts load together with the final scan sample so MOVE already presents them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx         <= '0;
      r_emax        <= '0;
      r_umin        <= '1;
      r_esum        <= '0;
      r_usum        <= '0;
      r_enemy_front <= '0;
      r_unit_front  <= '1;
      r_overrun     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_idx  <= '0;
            r_emax <= '0;
            r_umin <= '1;
            r_esum <= '0;
            r_usum <= '0;
          end
        end
        S_SCAN: begin
          r_emax <= w_emax_nxt;
          r_umin <= w_umin_nxt;
          r_idx  <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_enemy_front <= w_emax_nxt;
            r_unit_front  <= w_umin_nxt;
          end
        end
        S_DSCAN: begin
          r_esum <= w_esum_nxt;
          r_usum <= w_usum_nxt;
          r_idx  <= w_last ? '0 : r_idx + 1'b1;
        end
        default: ;
      endcase
      if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
    end
  end

  assign bus.enemy_front = r_enemy_front;
  assign bus.unit_front  = r_unit_front;
  assign bus.overrun     = r_overrun;

endmodule

// File: doc/battle_front_ctrl.md
Name: battle_front_ctrl

Overview:
- Drives the combat side of the unit interface for both armies. It generates the game-tick move strobe and damage strobe.
- Tracks the frontmost enemy (reported to player units) and the frontmost player unit (reported to enemies).
- Aggregates each army's attack output into the damage applied to the opposing army.
- Sits between the player unit array and the enemy array in the top level.

Parameters:
- NUM_UNITS, 4, unit slots per army; both arrays have the same size.
- TICK_DIV, 1000000, clk cycles per game tick; must be > 2*NUM_UNITS+3.
- POS_W, 9, position width.
- DMG_W, 8, damage width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  game running.
- unit_pos  in  NUM_UNITS*POS_W  packed player positions; slot i at [i*POS_W +: POS_W].
- unit_type  in  NUM_UNITS*2  packed player types; 00 = dead/empty.
- unit_dmg  in  NUM_UNITS*DMG_W  packed player damageOut.
- enemy_pos  in  NUM_UNITS*POS_W  packed enemy positions; enemies move toward higher positions.
- enemy_type  in  NUM_UNITS*2  packed enemy types; 00 = dead/empty.
- enemy_dmg  in  NUM_UNITS*DMG_W  packed enemy damageOut.
- moveSCEN  out  1  one-cycle move strobe to both arrays.
- damageSCEN  out  1  one-cycle damage strobe to both arrays.
- enemy_front  out  POS_W  largest alive enemy position; feeds player enemyFront.
- unit_front  out  POS_W  smallest alive player position; feeds enemy front input.
- damage_to_units  out  DMG_W  damageIn for player units.
- damage_to_enemies  out  DMG_W  damageIn for enemies.
- overrun  out  1  sticky: a tick arrived while a sequence was busy.

Behaviour:
- Reset (reset low, async):
  - State IDLE, tick counter 0.
  - moveSCEN = 0, damageSCEN = 0, overrun = 0.
  - enemy_front = 0, unit_front = all ones (511).
  - Both damage outputs 0.
- Tick counter:
  - Counts 0..TICK_DIV-1 while enable = 1, then wraps.
  - The cycle where count == TICK_DIV-1 is the tick.
  - enable = 0 clears the counter to 0 and produces no ticks.
- FSM: IDLE -> SCAN -> MOVE -> SETTLE -> DSCAN -> DAMAGE -> IDLE.
  - IDLE: on a tick, clear the min/max/sum accumulators; the next state is SCAN with index 0.
  - SCAN (NUM_UNITS cycles): each cycle samples slot index from both arrays.
    - Alive enemy: max-accumulate enemy_pos.
    - Alive unit: min-accumulate unit_pos.
    - Dead slots (type 00) are ignored.
  - MOVE (1 cycle): enemy_front and unit_front load from the accumulators on the entering edge; moveSCEN = 1 for exactly this cycle.
    - With no alive enemies, enemy_front = 0.
    - With no alive units, unit_front = 511.
  - SETTLE (1 cycle): lets the arrays register their new damageOut.
  - DSCAN (NUM_UNITS cycles): sums the alive enemy_dmg and alive unit_dmg.
    - Sums are held in DMG_W+clog2(NUM_UNITS)-bit accumulators.
    - Outputs saturate to all ones.
  - DAMAGE (1 cycle): damageSCEN = 1.
    - damage_to_units = saturated enemy sum; damage_to_enemies = saturated unit sum.
    - Both damage outputs are non-zero only in this cycle and 0 in every other cycle. Units compare health against damageIn every cycle, so this rule is mandatory.
- Latency from the tick cycle t0:
  - moveSCEN high at t0+NUM_UNITS+1.
  - damageSCEN high at t0+2*NUM_UNITS+3.
- Between sequences, the fronts hold their last values.
- A tick while not in IDLE is dropped and sets overrun; overrun clears only on reset.
- enable falling mid-sequence: the current sequence completes, including the strobes; there are no further ticks.
- Reset mid-sequence: immediate return to the reset values; no strobe occurs afterwards until a new tick.
- Inputs are sampled only in the SCAN and DSCAN cycles; changes at other times have no effect.

Optional Feature:
- Macro BATTLE_STEP_EN.
- When defined:
  - Adds input step (1 bit), synchronized through 2 flops.
  - A tick is the synchronized rising edge of step; TICK_DIV is unused.
  - enable still gates ticks.
  - Rising edges while busy set overrun.
- When undefined: no step port; ticks come from the divider only.

Test Plan:
Configuration: NUM_UNITS=4, TICK_DIV=16.
1. Release reset, enable=1, all types 00 -> moveSCEN pulses once every 16 cycles at t0+5 with enemy_front=0 and unit_front=511; damageSCEN at t0+11 with both damages 0.
2. enemy_pos {10,200,50,30} with slot1 type 00; unit_pos {300,120,511,400} with slot2 type 00 -> enemy_front=50 and unit_front=120 during moveSCEN.
3. Alive enemy_dmg {0x80,0x80,0x40,0}, alive unit_dmg {0x20,0x10,0,0} -> during damageSCEN, damage_to_units=0xFF and damage_to_enemies=0x30; both are 0 the cycle before and the cycle after.
4. Drop enable during SCAN -> that sequence's moveSCEN and damageSCEN still occur; no pulses for the following 64 cycles; counter reads 0.
5. Drive reset low during DSCAN -> outputs at reset values immediately; damageSCEN is not asserted for that sequence.
6. TICK_DIV=8 -> the second tick lands during the busy sequence; overrun=1 and stays 1; that tick produces no extra strobe.
